// File: rtl/ubit_pkg.sv
// ---------------------------------------------------------------------------
// ubit_pkg
// Shared definitions for the unary-to-binary window accumulator.
//   state_t  : controller states. WARMUP is always declared so the encoding
//              is identical in every build; it is only reachable when
//              UBIT_WIN_ACC_WARMUP_EN is defined.
//   win_len  : window length (number of valid bits) for a given DEP.
// ---------------------------------------------------------------------------
package ubit_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HOLD   = 2'd2,
      WARMUP = 2'd3
   } state_t;

   function automatic int win_len(input int dep);
      return 1 << dep;
   endfunction

endpackage

// File: rtl/ubit_cnt.sv
// ---------------------------------------------------------------------------
// ubit_cnt
// Generic up-counter with synchronous clear, count enable and a
// terminal-count flag. Wraps to zero after the all-ones value.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, counter -> 0
//   i_clr : synchronous clear (wins over i_en)
//   i_en  : increment by one
//   o_tc  : high while the count equals TERM
// ---------------------------------------------------------------------------
module ubit_cnt #(
   parameter int W    = 8,
   parameter int TERM = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = (r_cnt == W'(TERM));

endmodule

// File: rtl/ubit_win_acc.sv
// ---------------------------------------------------------------------------
// ubit_win_acc
// Counts the 1s of a unary bitstream over a window of 2^DEP valid bits and
// presents the binary count with a valid/ready handshake. Windows begin on
// a start pulse; a start coinciding with the output handshake opens the
// next window with no idle gap.
//
// Optional build macro: UBIT_WIN_ACC_WARMUP_EN
//   When defined, each window is preceded by WARM discarded valid bits so
//   the upstream kernel's settling transient is not counted.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : one-cycle request to begin a new window
//   in_bit   : unary bitstream sample
//   in_vld   : in_bit qualifier
//   out_data : ones count of the completed window (0 .. 2^DEP)
//   out_vld  : out_data valid
//   out_rdy  : downstream accepts out_data
//   busy     : high whenever the controller is not idle
// ---------------------------------------------------------------------------
module ubit_win_acc
   import ubit_pkg::*;
#(
   parameter int DEP  = 8,
   parameter int WARM = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         in_bit,
   input  logic         in_vld,
   output logic [DEP:0] out_data,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic         busy
);

   localparam int WIN_TERM = win_len(DEP) - 1;

`ifdef UBIT_WIN_ACC_WARMUP_EN
   localparam state_t START_ST = WARMUP;
`else
   localparam state_t START_ST = RUN;
`endif

   // Reject a warm-up length of zero at elaboration time.
   if (WARM < 1) begin : g_warm_chk
      $error("ubit_win_acc: WARM must be at least 1");
   end

   state_t       r_state;
   state_t       w_state_next;
   logic [DEP:0] r_acc;
   logic [DEP:0] r_out_data;
   logic         r_out_vld;

   logic w_accept;   // valid bit counted into the window
   logic w_win_tc;   // window counter sits on its final position
   logic w_last;     // this cycle samples the final window bit
   logic w_hs;       // output handshake completes
   logic w_clr;      // a new window opens this cycle

   assign w_accept = (r_state == RUN) && in_vld;
   assign w_last   = w_accept && w_win_tc;
   assign w_hs     = (r_state == HOLD) && r_out_vld && out_rdy;
   assign w_clr    = ((r_state == IDLE) && start) || (w_hs && start);

   ubit_cnt #(
      .W    (DEP),
      .TERM (WIN_TERM)
   ) u_win_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (w_accept),
      .o_tc  (w_win_tc)
   );

`ifdef UBIT_WIN_ACC_WARMUP_EN
   logic w_warm_en;
   logic w_warm_tc;

   assign w_warm_en = (r_state == WARMUP) && in_vld;

   ubit_cnt #(
      .W    ($clog2(WARM + 1)),
      .TERM (WARM - 1)
   ) u_warm_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (w_warm_en),
      .o_tc  (w_warm_tc)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = START_ST;
            end
         end
`ifdef UBIT_WIN_ACC_WARMUP_EN
         WARMUP: begin
            if (w_warm_en && w_warm_tc) begin
               w_state_next = RUN;
            end
         end
`endif
         RUN: begin
            if (w_last) begin
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            if (w_hs) begin
               w_state_next = start ? START_ST : IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // acc is one bit wider than win_cnt so a window of all ones reports
   // 2^DEP instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (w_clr) begin
         r_acc <= '0;
      end else if (w_accept) begin
         r_acc <= r_acc + {{DEP{1'b0}}, in_bit};
      end
   end

   // The final bit is folded in directly so the result appears one clock
   // after it is sampled. out_data is left untouched after the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data <= '0;
         r_out_vld  <= 1'b0;
      end else if (w_last) begin
         r_out_data <= r_acc + {{DEP{1'b0}}, in_bit};
         r_out_vld  <= 1'b1;
      end else if (w_hs) begin
         r_out_vld  <= 1'b0;
      end
   end

   assign out_data = r_out_data;
   assign out_vld  = r_out_vld;
   assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ubit_win_acc.sv
// ---------------------------------------------------------------------------
// tb_ubit_win_acc
// Self-checking bench for ubit_win_acc with DEP=4, WARM=4. Every cycle is
// compared against a behavioural model that collects accepted bits in a
// queue and sums them when the window is full; directed windows come from
// a table and a few hand-written sequences cover stall, back-to-back,
// reset-abort and warm-up behaviour.
// ---------------------------------------------------------------------------
module tb_ubit_win_acc;

   localparam int DEP  = 4;
   localparam int WARM = 4;
   localparam int WIN  = 1 << DEP;
`ifdef UBIT_WIN_ACC_WARMUP_EN
   localparam int WARM_BITS = WARM;
`else
   localparam int WARM_BITS = 0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         in_bit;
   logic         in_vld;
   logic         out_rdy;
   logic [DEP:0] out_data;
   logic         out_vld;
   logic         busy;

   ubit_win_acc #(
      .DEP  (DEP),
      .WARM (WARM)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_bit   (in_bit),
      .in_vld   (in_vld),
      .out_data (out_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: 0 idle, 1 warming up, 2 collecting, 3 holding.
   int m_phase;
   bit m_bits[$];
   int m_warm;
   int m_data;
   bit m_vld;

   typedef struct {
      logic [15:0] pat;
      int          gap;
      int          exp;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_bits.delete();
      m_warm = 0;
      m_data = 0;
      m_vld  = 1'b0;
   endtask

   task automatic model_open();
      m_bits.delete();
      m_warm  = 0;
      m_phase = (WARM_BITS > 0) ? 1 : 2;
   endtask

   task automatic model_step(input bit s, input bit b, input bit v, input bit r);
      case (m_phase)
         0: if (s) model_open();
         1: if (v) begin
               m_warm++;
               if (m_warm == WARM_BITS) m_phase = 2;
            end
         2: if (v) begin
               m_bits.push_back(b);
               if (m_bits.size() == WIN) begin
                  m_data = 0;
                  foreach (m_bits[k]) m_data += int'(m_bits[k]);
                  m_vld   = 1'b1;
                  m_phase = 3;
               end
            end
         default: if (r) begin
               m_vld = 1'b0;
               if (s) model_open();
               else m_phase = 0;
            end
      endcase
   endtask

   // One clock: drive inputs, advance the model, compare after the edge.
   task automatic tick(input bit s, input bit b, input bit v, input bit r);
      start   = s;
      in_bit  = b;
      in_vld  = v;
      out_rdy = r;
      model_step(s, b, v, r);
      @(posedge clk);
      #1;
      check("model_vld",  int'(out_vld),  int'(m_vld));
      check("model_data", int'(out_data), m_data);
      check("model_busy", int'(busy),     int'(m_phase != 0));
   endtask

   task automatic warm_feed();
      for (int i = 0; i < WARM_BITS; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   // Feed 16 valid bits of pat (LSB first), inserting an invalid cycle
   // every gap-th cycle when gap is nonzero.
   task automatic feed_window(input logic [15:0] pat, input int gap, input string tag);
      int fed;
      int c;
      fed = 0;
      c   = 0;
      while (fed < WIN) begin
         if (gap != 0 && (c % gap) == gap - 1) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
         end else begin
            if (fed == WIN - 1) check({tag, "_vld_early"}, int'(out_vld), 0);
            tick(1'b0, pat[fed], 1'b1, 1'b0);
            fed++;
         end
         c++;
      end
   endtask

   initial begin
      tbl[0] = '{pat: 16'hFFFF, gap: 0, exp: 16};
      tbl[1] = '{pat: 16'h5555, gap: 3, exp: 8};
      tbl[2] = '{pat: 16'h0000, gap: 0, exp: 0};
      tbl[3] = '{pat: 16'h8001, gap: 2, exp: 2};
      tbl[4] = '{pat: 16'h0F0F, gap: 0, exp: 8};

      rst = 1'b1; start = 1'b0; in_bit = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
      model_reset();
      #12;
      check("reset_vld",  int'(out_vld),  0);
      check("reset_data", int'(out_data), 0);
      check("reset_busy", int'(busy),     0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven windows.
      for (int t = 0; t < 5; t++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         check("tbl_busy_after_start", int'(busy), 1);
         warm_feed();
         feed_window(tbl[t].pat, tbl[t].gap, "tbl");
         check("tbl_vld",  int'(out_vld),  1);
         check("tbl_data", int'(out_data), tbl[t].exp);
         $display("[TB] window %0d pat=%h gap=%0d data=%0d", t, tbl[t].pat, tbl[t].gap, out_data);
         tick(1'b0, 1'b0, 1'b0, 1'b1);
         check("tbl_vld_drop", int'(out_vld), 0);
         check("tbl_idle",     int'(busy),    0);
      end

      // Stall in HOLD: ones keep arriving and a lone start is ignored.
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      warm_feed();
      feed_window(16'h00FF, 0, "stall");
      for (int i = 0; i < 5; i++) begin
         tick((i == 2), 1'b1, 1'b1, 1'b0);
         check("stall_vld",  int'(out_vld),  1);
         check("stall_data", int'(out_data), 8);
      end
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      check("stall_release_busy", int'(busy), 0);
      $display("[TB] stall sequence data=%0d", out_data);

      // Back-to-back windows via start on the handshake cycle.
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      warm_feed();
      feed_window(16'h0000, 0, "b2b0");
      check("b2b_first_data", int'(out_data), 0);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      check("b2b_no_idle", int'(busy),    1);
      check("b2b_vld_low", int'(out_vld), 0);
      warm_feed();
      feed_window(16'hFFFF, 0, "b2b1");
      check("b2b_second_data", int'(out_data), 16);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      $display("[TB] back-to-back second data=%0d", out_data);

      // Reset mid-window discards the partial count.
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      warm_feed();
      for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      #2;
      check("abort_vld",  int'(out_vld),  0);
      check("abort_data", int'(out_data), 0);
      check("abort_busy", int'(busy),     0);
      model_reset();
      #2;
      rst = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      warm_feed();
      feed_window(16'hFFFF, 0, "abort");
      check("abort_next_data", int'(out_data), 16);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      $display("[TB] after abort data=%0d", out_data);

      // Warm-up: 4 ones then zeros.
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef UBIT_WIN_ACC_WARMUP_EN
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check("warm_vld_early", int'(out_vld), 0);
         tick(1'b0, 1'b0, 1'b1, 1'b0);
      end
      check("warm_vld",  int'(out_vld),  1);
      check("warm_data", int'(out_data), 0);
`else
      for (int i = 0; i < 12; i++) begin
         if (i == 11) check("warm_vld_early", int'(out_vld), 0);
         tick(1'b0, 1'b0, 1'b1, 1'b0);
      end
      check("warm_vld",  int'(out_vld),  1);
      check("warm_data", int'(out_data), 4);
`endif
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      $display("[TB] warm-up sequence data=%0d", out_data);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
              1'($urandom));
      end
      $display("[TB] random phase done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
